uart_host_ctrl: RTL and testbench

Bus-side initiator for the CoreUART parallel interface. It converts a byte-stream transmit channel (valid/ready) into CSN/WEN write strobes and polls RXRDY to issue CSN/OEN read strobes, returning received bytes plus sampled error flags on a byte-stream receive channel. It sits between fabric logic with no bus and the UART core, replacing a CPU/APB master for hardwired links. It also maintains a saturating receive-error counter.

---
 rtl/uart_host_ctrl_if.sv | 21 ++
 rtl/uart_host_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_host_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_host_ctrl_if.sv
// Byte-stream channels between fabric logic and uart_host_ctrl.
// slave: the controller side. master: the fabric side.
interface uart_host_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic [2:0] rx_err;
  logic       rx_valid;
  logic       rx_ready;

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_err, rx_valid
  );

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_err, rx_valid
  );
endinterface

// File: rtl/uart_host_ctrl.sv
// Bus-side initiator for the CoreUART parallel interface: turns a transmit
// byte stream into CSN/WEN write strobes, polls RXRDY to issue CSN/OEN read
// strobes, returns received bytes with error flags, and counts error reads.
module uart_host_ctrl #(
  parameter bit          RX_PRIORITY   = 1'b1,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  uart_host_ctrl_if.slave       host,
  output logic [7:0]            err_cnt,
  input  logic                  err_cnt_clr,
  output logic                  CSN,
  output logic                  WEN,
  output logic                  OEN,
  output logic [7:0]            DATA_IN,
  input  logic [7:0]            DATA_OUT,
  input  logic                  TXRDY,
  input  logic                  RXRDY,
  input  logic                  PARITY_ERR,
  input  logic                  FRAMING_ERR,
  input  logic                  OVERFLOW
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, SETTLE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       rd_elig, wr_elig, grant_rd, grant_wr;
  logic [7:0] rx_data_q;
  logic [2:0] rx_err_q;
  logic       rx_valid_q;

  assign host.tx_ready = grant_wr;
  assign host.rx_data  = rx_data_q;
  assign host.rx_err   = rx_err_q;
  assign host.rx_valid = rx_valid_q;

  // Arbitration in IDLE and next-state selection.
  // Write eligibility is gated by RESET_N so tx_ready reads 0 while in reset.
  always_comb begin
    state_nxt = state;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    rd_elig   = RXRDY & ~rx_valid_q;
    wr_elig   = host.tx_valid & TXRDY & RESET_N;
    unique case (state)
      IDLE: begin
        if (rd_elig && (RX_PRIORITY || !wr_elig)) begin
          grant_rd  = 1'b1;
          state_nxt = READ;
        end else if (wr_elig) begin
          grant_wr  = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE:   state_nxt = SETTLE;
      READ:    state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Settle-cycle counter: runs only while in SETTLE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)              settle_cnt <= '0;
    else if (state != SETTLE)  settle_cnt <= '0;
    else                       settle_cnt <= settle_cnt + 4'd1;
  end

  // Strobes are registered from the next state so they are glitch-free and
  // low for exactly the one WRITE/READ cycle; DATA_IN holds the last byte.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CSN     <= 1'b1;
      WEN     <= 1'b1;
      OEN     <= 1'b1;
      DATA_IN <= '0;
    end else begin
      CSN <= (state_nxt != WRITE) && (state_nxt != READ);
      WEN <= (state_nxt != WRITE);
      OEN <= (state_nxt != READ);
      if (grant_wr) DATA_IN <= host.tx_data;
    end
  end

  // Receive capture at the end of the READ cycle; held until consumed.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_data_q  <= '0;
      rx_err_q   <= '0;
      rx_valid_q <= 1'b0;
    end else if (state == READ) begin
      rx_data_q  <= DATA_OUT;
      rx_err_q   <= {OVERFLOW, FRAMING_ERR, PARITY_ERR};
      rx_valid_q <= 1'b1;
    end else if (rx_valid_q && host.rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

  // Saturating error-read counter; clear wins over increment.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if ((state == READ) && ({OVERFLOW, FRAMING_ERR, PARITY_ERR} != 3'b000)
                 && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Testbench for uart_host_ctrl: directed boundary checks followed by a
// randomized run checked by a queue scoreboard and a separate monitor.
module tb_uart_host_ctrl;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] err_cnt, err_cnt0, data_in, data_in0, data_out;
  logic       err_cnt_clr;
  logic       csn, wen, oen, csn0, wen0, oen0;
  logic       txrdy, rxrdy, perr, ferr, ovf;

  uart_host_ctrl_if bus ();
  uart_host_ctrl_if bus0 ();

  assign bus0.tx_data  = bus.tx_data;
  assign bus0.tx_valid = bus.tx_valid;
  assign bus0.rx_ready = 1'b1;

  uart_host_ctrl #(.RX_PRIORITY(1'b1), .SETTLE_CYCLES(S)) dut (
    .CLK(clk), .RESET_N(rst_n), .host(bus), .err_cnt(err_cnt), .err_cnt_clr(err_cnt_clr),
    .CSN(csn), .WEN(wen), .OEN(oen), .DATA_IN(data_in), .DATA_OUT(data_out),
    .TXRDY(txrdy), .RXRDY(rxrdy), .PARITY_ERR(perr), .FRAMING_ERR(ferr), .OVERFLOW(ovf)
  );

  uart_host_ctrl #(.RX_PRIORITY(1'b0), .SETTLE_CYCLES(S)) dut_wp (
    .CLK(clk), .RESET_N(rst_n), .host(bus0), .err_cnt(err_cnt0), .err_cnt_clr(err_cnt_clr),
    .CSN(csn0), .WEN(wen0), .OEN(oen0), .DATA_IN(data_in0), .DATA_OUT(data_out),
    .TXRDY(txrdy), .RXRDY(rxrdy), .PARITY_ERR(perr), .FRAMING_ERR(ferr), .OVERFLOW(ovf)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit sb_on = 1'b0;
  bit tx_hold = 1'b0;
  int model_errs = 0;

  typedef struct { logic [7:0] d; int cyc; } tx_exp_t;
  typedef struct { logic [7:0] d; logic [2:0] e; logic [7:0] c; int cyc; } rx_exp_t;
  tx_exp_t txq[$];
  rx_exp_t rxq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One stimulus cycle; pushes expected results for what the UART model
  // and the transmit source observe this cycle.
  task automatic step(input bit quiet);
    @(negedge clk);
    if (quiet) begin
      if (!tx_hold) bus.tx_valid = 1'b0;
      txrdy = 1'b1;
      rxrdy = 1'b0;
      bus.rx_ready = 1'b1;
      {ovf, ferr, perr} = 3'b000;
    end else begin
      if (!tx_hold) begin
        bus.tx_valid = ($urandom % 3) != 0;
        bus.tx_data  = 8'($urandom);
      end
      txrdy = ($urandom % 4) != 0;
      rxrdy = ($urandom % 2) != 0;
      perr  = ($urandom % 6) == 0;
      ferr  = ($urandom % 8) == 0;
      ovf   = ($urandom % 10) == 0;
      bus.rx_ready = ($urandom % 5) < 3;
    end
    data_out = 8'($urandom);
    #1;
    tx_hold = bus.tx_valid && !bus.tx_ready;
    if (bus.tx_valid && bus.tx_ready) txq.push_back('{bus.tx_data, cyc});
    if (!csn && !oen) begin
      if ({ovf, ferr, perr} != 3'b000 && model_errs < 255) model_errs++;
      rxq.push_back('{data_out, {ovf, ferr, perr}, 8'(model_errs), cyc});
    end
  endtask

  // Monitor: pops expectations when the DUT presents strobes or rx data.
  initial begin : monitor
    int last_strobe;
    bit prev_rxv;
    tx_exp_t t;
    rx_exp_t r;
    last_strobe = -100;
    prev_rxv = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!sb_on) begin
        last_strobe = -100;
        prev_rxv = bus.rx_valid;
        continue;
      end
      if (!csn) begin
        check("strobe_spacing_ok", 32'(cyc - last_strobe >= 2 + S), 1);
        last_strobe = cyc;
        check("one_enable_low", 32'(wen != oen), 1);
        if (!wen) begin
          if (txq.size() == 0) check("write_without_accept", 0, 1);
          else begin
            t = txq.pop_front();
            check("wr_data", data_in, t.d);
            check("wr_latency", cyc - t.cyc, 1);
          end
        end
        if (!oen) check("read_while_rx_valid", bus.rx_valid, 0);
      end
      if (bus.rx_valid && !prev_rxv) begin
        if (rxq.size() == 0) check("rx_valid_without_read", 0, 1);
        else check("rx_latency", cyc - rxq[0].cyc, 1);
      end
      if (bus.rx_valid && bus.rx_ready && rxq.size() != 0) begin
        r = rxq.pop_front();
        check("rx_data", bus.rx_data, r.d);
        check("rx_err", bus.rx_err, r.e);
        check("err_cnt", err_cnt, r.c);
      end
      if (!txrdy) check("tx_ready_without_txrdy", bus.tx_ready, 0);
      prev_rxv = bus.rx_valid;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nread;
    bit seen;
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b1;
    bus.rx_ready = 1'b0;
    txrdy = 1'b1; rxrdy = 1'b0;
    {ovf, ferr, perr} = 3'b000;
    data_out = 8'h00;
    err_cnt_clr = 1'b0;

    // Reset values
    #12;
    check("rst_csn", csn, 1);
    check("rst_wen", wen, 1);
    check("rst_oen", oen, 1);
    check("rst_data_in", data_in, 0);
    check("rst_tx_ready", bus.tx_ready, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_err", bus.rx_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    bus.tx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: read wins with RX_PRIORITY=1, write wins with 0
    @(negedge clk);
    bus.tx_data = 8'h5A; bus.tx_valid = 1'b1; txrdy = 1'b1; rxrdy = 1'b1;
    data_out = 8'h3C; bus.rx_ready = 1'b0;
    #1;
    check("prio_rd_tx_ready", bus.tx_ready, 0);
    check("prio_wr_tx_ready", bus0.tx_ready, 1);
    @(negedge clk); #1;
    check("prio_rd_strobes", {csn, wen, oen}, 3'b010);
    check("prio_wr_strobes", {csn0, wen0, oen0}, 3'b001);
    check("prio_wr_data", data_in0, 8'h5A);
    check("settle1_tx_ready", bus.tx_ready, 0);
    @(negedge clk); #1;
    check("rd_rx_valid", bus.rx_valid, 1);
    check("rd_rx_data", bus.rx_data, 8'h3C);
    check("rd_rx_err", bus.rx_err, 0);
    check("rd_err_cnt", err_cnt, 0);
    check("rd_strobes_high", {csn, wen, oen}, 3'b111);
    check("settle2_tx_ready", bus.tx_ready, 0);
    @(negedge clk); #1;
    check("settle3_tx_ready", bus.tx_ready, 0);
    @(negedge clk); #1;
    check("write_after_settle", bus.tx_ready, 1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    #1;
    check("wr_strobes", {csn, wen, oen}, 3'b001);
    check("wr_data_in", data_in, 8'h5A);

    // Back-pressure: rx_valid held, RXRDY=1, no further reads; TXRDY=0 blocks tx
    txrdy = 1'b0; bus.tx_valid = 1'b1; bus.tx_data = 8'h77; data_out = 8'hC3;
    nread = 0; seen = 1'b0;
    repeat (12) begin
      @(negedge clk); #1;
      if (!csn && !oen) nread++;
      if (bus.tx_ready) seen = 1'b1;
    end
    check("bp_no_read", nread, 0);
    check("bp_rx_valid_held", bus.rx_valid, 1);
    check("txrdy0_no_tx_ready", seen, 0);
    bus.tx_valid = 1'b0; txrdy = 1'b1;
    @(negedge clk); bus.rx_ready = 1'b1;
    @(negedge clk); bus.rx_ready = 1'b0;
    nread = 0;
    repeat (12) begin
      #1;
      if (!csn && !oen) nread++;
      @(negedge clk);
    end
    check("bp_second_read", nread, 1);
    check("bp_second_data", bus.rx_data, 8'hC3);

    // Error counter saturation
    do_reset();
    rxrdy = 1'b1; bus.rx_ready = 1'b1; perr = 1'b1;
    nread = 0;
    for (int i = 0; i < 1500 && nread < 256; i++) begin
      @(negedge clk); #1;
      if (!csn && !oen) begin
        nread++;
        if (nread == 256) rxrdy = 1'b0;
      end else if (bus.rx_valid && nread == 255) begin
        check("err_cnt_at_255", err_cnt, 8'd255);
      end
    end
    check("err_reads_done", nread, 256);
    @(negedge clk); #1;
    check("sat_rx_valid", bus.rx_valid, 1);
    check("sat_rx_err", bus.rx_err, 3'b001);
    check("sat_err_cnt", err_cnt, 8'd255);

    // Clear coincident with an error read
    rxrdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (!csn && !oen) begin
        seen = 1'b1;
        err_cnt_clr = 1'b1;
        rxrdy = 1'b0;
      end
    end
    check("clr_read_seen", seen, 1);
    @(negedge clk);
    err_cnt_clr = 1'b0;
    #1;
    check("clr_wins", err_cnt, 0);
    check("clr_rx_err", bus.rx_err, 3'b001);
    perr = 1'b0;

    // Reset during the write strobe cycle
    @(negedge clk);
    txrdy = 1'b1; rxrdy = 1'b0; bus.tx_valid = 1'b1; bus.tx_data = 8'h96;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      #1;
      if (bus.tx_ready) seen = 1'b1;
      else @(negedge clk);
    end
    check("rw_tx_ready_seen", seen, 1);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    #1;
    check("rw_wen_low", wen, 0);
    rst_n = 1'b0;
    #1;
    check("rw_csn_high", csn, 1);
    check("rw_wen_high", wen, 1);
    check("rw_data_in", data_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rw_tx_ready", bus.tx_ready, 0);
    check("rw_rx_valid", bus.rx_valid, 0);
    bus.tx_valid = 1'b1;
    #1;
    check("rw_idle_grant", bus.tx_ready, 1);
    bus.tx_valid = 1'b0;
    @(negedge clk); #1;
    check("rw_no_partial", {csn, wen, oen}, 3'b111);

    // Randomized run against the scoreboard
    do_reset();
    model_errs = 0;
    tx_hold = 1'b0;
    txq.delete();
    rxq.delete();
    sb_on = 1'b1;
    repeat (3000) step(1'b0);
    repeat (16) step(1'b1);
    check("txq_drained", txq.size(), 0);
    check("rxq_drained", rxq.size(), 0);
    sb_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
